// File: rtl/fetch_stage_if.sv
// Bundles the fetch stage's redirect, decode handshake, instruction-memory and IF/ID signals.
// The master modport is the fetch stage side.
interface fetch_stage_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        fetch_fault;

    modport master (
        input  redirect_valid, redirect_pc, id_ready, imem_instr,
        output imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc4, fetch_fault
    );

    modport slave (
        output redirect_valid, redirect_pc, id_ready, imem_instr,
        input  imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc4, fetch_fault
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC register, async instruction-memory address, one-entry IF/ID register.
// Optional FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   perf_fetch_cnt,
    output logic [31:0]   perf_stall_cnt
`endif
);

    localparam logic [0:0]  ST_RUN     = 1'b0;
    localparam logic [0:0]  ST_HALT    = 1'b1;
    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    logic [0:0]  state;
    logic [31:0] pc_p0;
    logic        vld_p1;
    logic [31:0] instr_p1;
    logic [31:0] pc_p1;
    logic [31:0] pc4_p1;
    logic        fault;

    logic        running;
    logic        advance;
    logic        pc_legal;
    logic        target_legal;
    logic        capture;
    logic        stall;

    function automatic logic addr_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ({1'b0, a} < IMEM_LIMIT);
    endfunction

    always_comb begin
        running      = (state == ST_RUN);
        advance      = running && (!vld_p1 || bus.id_ready);
        pc_legal     = addr_legal(pc_p0);
        target_legal = addr_legal(bus.redirect_pc);
        capture      = advance && !bus.redirect_valid && pc_legal;
        stall        = running && vld_p1 && !bus.id_ready;
    end

    // Stage p0 -> p1: PC update and IF/ID capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            pc_p0    <= RESET_PC;
            vld_p1   <= 1'b0;
            instr_p1 <= NOP;
            pc_p1    <= 32'h0;
            pc4_p1   <= 32'h0;
            fault    <= 1'b0;
        end else if (running) begin
            if (bus.redirect_valid) begin
                // Target is kept in pc_p0 even when illegal so the faulting address is visible.
                pc_p0  <= bus.redirect_pc;
                vld_p1 <= 1'b0;
                if (!target_legal) begin
                    fault <= 1'b1;
                    state <= ST_HALT;
                end
            end else if (advance) begin
                if (!pc_legal) begin
                    fault  <= 1'b1;
                    state  <= ST_HALT;
                    vld_p1 <= 1'b0;
                end else begin
                    instr_p1 <= bus.imem_instr;
                    pc_p1    <= pc_p0;
                    pc4_p1   <= pc_p0 + 32'd4;
                    vld_p1   <= 1'b1;
                    pc_p0    <= pc_p0 + 32'd4;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= 32'h0;
            perf_stall_cnt <= 32'h0;
        end else begin
            if (capture) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall)   perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = capture ^ stall;
`endif

    assign bus.imem_addr   = pc_p0;
    assign bus.if_id_valid = vld_p1;
    assign bus.if_id_instr = instr_p1;
    assign bus.if_id_pc    = pc_p1;
    assign bus.if_id_pc4   = pc4_p1;
    assign bus.fetch_fault = fault;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed stimulus with literal expectations plus a per-cycle
// instruction-stream model checked on every falling edge.
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          IMEM_WORDS = 64;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic clk;
    logic reset;
    fetch_stage_if bus ();
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage #(.RESET_PC(RESET_PC), .IMEM_WORDS(IMEM_WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image; a few words are fixed so the directed checks can name them literally.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [29:0] idx;
        idx = a[31:2];
        if (a >= 32'(IMEM_WORDS * 4)) return 32'hDEAD_BEEF;
        case (idx)
            30'd1:   return 32'h0050_0113;
            30'd2:   return 32'h00C0_0193;
            30'd3:   return 32'hFF71_8393;
            30'd11:  return 32'h0023_A233;
            default: return 32'h1000_0000 | {idx[23:0], 8'h37};
        endcase
    endfunction

    assign bus.imem_instr = mem_word(bus.imem_addr);

    function automatic logic legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < 32'(IMEM_WORDS * 4));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stream of instructions decode should see, next fetch address, fault flag.
    logic        m_ok = 1'b0;
    logic        m_valid, m_fault, m_fresh;
    logic [31:0] m_pc, m_next;
    int unsigned m_fcnt, m_scnt;

    always @(negedge clk) begin
        if (m_ok) begin
            chk("mdl_valid", 32'(bus.if_id_valid), 32'(m_valid));
            chk("mdl_fault", 32'(bus.fetch_fault), 32'(m_fault));
            chk("mdl_addr", bus.imem_addr, m_next);
            if (m_valid) begin
                chk("mdl_pc", bus.if_id_pc, m_pc);
                chk("mdl_instr", bus.if_id_instr, mem_word(m_pc));
                chk("mdl_pc4", bus.if_id_pc4, m_pc + 32'd4);
            end else if (m_fresh) begin
                chk("mdl_rst_instr", bus.if_id_instr, NOP);
                chk("mdl_rst_pc", bus.if_id_pc, 32'h0);
            end
`ifdef FETCH_PERF_CNT_EN
            chk("mdl_fcnt", perf_fetch_cnt, m_fcnt);
            chk("mdl_scnt", perf_stall_cnt, m_scnt);
`endif
        end
        if (reset) begin
            m_ok = 1'b1; m_valid = 1'b0; m_fault = 1'b0; m_fresh = 1'b1;
            m_pc = 32'h0; m_next = RESET_PC; m_fcnt = 0; m_scnt = 0;
        end else if (m_ok && !m_fault) begin
            if (m_valid && !bus.id_ready) m_scnt++;
            if (bus.redirect_valid) begin
                m_valid = 1'b0;
                m_next  = bus.redirect_pc;
                if (!legal(bus.redirect_pc)) m_fault = 1'b1;
            end else if (!m_valid || bus.id_ready) begin
                if (!legal(m_next)) begin
                    m_fault = 1'b1;
                    m_valid = 1'b0;
                end else begin
                    m_valid = 1'b1;
                    m_pc    = m_next;
                    m_next  = m_next + 32'd4;
                    m_fresh = 1'b0;
                    m_fcnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [31:0] pc,
                              input logic [31:0] instr);
        chk({name, "_valid"}, 32'(bus.if_id_valid), 32'(v));
        chk({name, "_pc"}, bus.if_id_pc, pc);
        chk({name, "_instr"}, bus.if_id_instr, instr);
    endtask

    initial begin
        logic found;
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.id_ready       = 1'b1;
        tick(); tick();
        chk("rst_valid", 32'(bus.if_id_valid), 32'h0);
        chk("rst_instr", bus.if_id_instr, NOP);
        chk("rst_pc4", bus.if_id_pc4, 32'h0);
        chk("rst_fault", 32'(bus.fetch_fault), 32'h0);

        // Sequential fetch
        reset = 1'b0;
        tick(); expect_out("seq0", 1'b1, 32'h00, 32'h1000_0037);
        tick(); expect_out("seq4", 1'b1, 32'h04, 32'h0050_0113);
        chk("seq4_pc4", bus.if_id_pc4, 32'h08);
        tick(); expect_out("seq8", 1'b1, 32'h08, 32'h00C0_0193);
        tick(); expect_out("seqC", 1'b1, 32'h0C, 32'hFF71_8393);

        // Stall for three edges
        bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_out("stall", 1'b1, 32'h0C, 32'hFF71_8393);
        end
        bus.id_ready = 1'b1;
        tick(); expect_out("post_stall", 1'b1, 32'h10, 32'h1000_0437);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall_3", perf_stall_cnt, 32'd3);
        chk("perf_fetch_5", perf_fetch_cnt, 32'd5);
`endif

        // Redirect from 0x24 to 0x2C
        for (int i = 0; i < 5; i++) tick();
        chk("at24_pc", bus.if_id_pc, 32'h24);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h2C;
        tick(); bus.redirect_valid = 1'b0;
        chk("redir_flush", 32'(bus.if_id_valid), 32'h0);
        tick(); expect_out("redir_tgt", 1'b1, 32'h2C, 32'h0023_A233);

        // Redirect while stalled
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h4C;
        tick(); bus.redirect_valid = 1'b0;
        chk("rds_flush", 32'(bus.if_id_valid), 32'h0);
        tick();
        chk("rds_pc", bus.if_id_pc, 32'h4C);
        chk("rds_pc4", bus.if_id_pc4, 32'h50);
        bus.id_ready = 1'b1;

        // Misaligned redirect target halts the stage
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h06;
        tick(); bus.redirect_valid = 1'b0;
        chk("flt_fault", 32'(bus.fetch_fault), 32'h1);
        chk("flt_valid", 32'(bus.if_id_valid), 32'h0);
        chk("flt_addr", bus.imem_addr, 32'h06);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h10;
        tick(); tick(); bus.redirect_valid = 1'b0;
        chk("halt_addr", bus.imem_addr, 32'h06);
        chk("halt_valid", 32'(bus.if_id_valid), 32'h0);

        // Reset from HALT, then fall through the end of memory
        reset = 1'b1;
        tick(); reset = 1'b0;
        chk("rh_fault", 32'(bus.fetch_fault), 32'h0);
        chk("rh_valid", 32'(bus.if_id_valid), 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rh_pfetch", perf_fetch_cnt, 32'h0);
        chk("rh_pstall", perf_stall_cnt, 32'h0);
`endif
        tick(); expect_out("rh_first", 1'b1, RESET_PC, 32'h1000_0037);
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (bus.if_id_valid && bus.if_id_pc == 32'hFC) found = 1'b1;
            else tick();
        end
        chk("reach_FC", 32'(found), 32'h1);
        tick();
        chk("end_fault", 32'(bus.fetch_fault), 32'h1);
        chk("end_valid", 32'(bus.if_id_valid), 32'h0);
        chk("end_addr", bus.imem_addr, 32'h100);

        // Reset in the middle of a stall
        reset = 1'b1;
        tick(); reset = 1'b0;
        tick();
        bus.id_ready = 1'b0;
        tick(); tick();
        chk("ms_hold", bus.if_id_pc, 32'h0);
        reset = 1'b1;
        tick(); reset = 1'b0;
        chk("ms_valid", 32'(bus.if_id_valid), 32'h0);
        chk("ms_fault", 32'(bus.fetch_fault), 32'h0);
        tick(); expect_out("ms_first", 1'b1, RESET_PC, 32'h1000_0037);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
